wb_stage: RTL
=============

WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 The block SHALL use clock clk and reset rstn; rstn is asynchronous, active-low.
REQ-002 The block SHALL have these ports (name  direction  width  meaning):
- clk  in  1  clock
- rstn  in  1  async active-low reset
- alu_valid  in  1  ALU result offered
- alu_ready  out  1  ALU result accepted this cycle when high with alu_valid
- alu_rd  in  5  ALU destination register
- alu_result  in  32  ALU result
- mem_valid  in  1  load data offered; always accepted, no ready
- mem_rd  in  5  load destination register
- mem_funct3  in  3  load type (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU)
- mem_addr_lo  in  2  load byte address bits [1:0]
- mem_rdata  in  32  raw word from data memory
- wr_en  out  1  register-file write enable
- wr_addr  out  5  register-file write address
- wr_data  out  32  register-file write data
- load_err  out  1  one-cycle pulse: misaligned or illegal load
- wb_count  out  32  committed register writes

Function
REQ-003 wr_en, wr_addr, wr_data, load_err SHALL be registered; latency from accepted input to wr_en SHALL be exactly 1 cycle.
REQ-004 The block SHALL hold one ALU entry in a hold buffer (hold_v, hold_rd, hold_data).
REQ-005 alu_ready SHALL equal !hold_v, combinationally.
REQ-006 Source priority per cycle SHALL be: mem input > hold buffer > ALU input.
REQ-007 mem_valid with accepted ALU input (hold empty): SHALL write mem result and capture ALU into hold.
REQ-008 mem_valid with hold_v=1: SHALL write mem result; hold SHALL be unchanged.
REQ-009 mem_valid=0, hold_v=1: SHALL write hold entry and clear hold_v; ALU input SHALL NOT be accepted that cycle.
REQ-010 mem_valid=0, hold_v=0, alu_valid=1: SHALL write ALU result directly.
REQ-011 No selected source: next cycle wr_en=0; wr_addr/wr_data SHALL hold their previous values.
REQ-012 Selected destination 0: SHALL be consumed with next-cycle wr_en=0 and no wb_count increment.
REQ-013 LB/LBU SHALL select byte mem_rdata[8*addr_lo +: 8]; LB sign-extends, LBU zero-extends.
REQ-014 LH/LHU SHALL select halfword mem_rdata[16*addr_lo[1] +: 16]; LH sign-extends, LHU zero-extends.
REQ-015 LW SHALL pass mem_rdata unchanged.
REQ-016 LH/LHU with addr_lo[0]=1, LW with addr_lo!=0, or funct3 in {011,110,111} SHALL produce next-cycle wr_en=0 and load_err=1 for one cycle; the load is consumed.
REQ-017 wb_count SHALL increment by 1 on every cycle wr_en=1, wrapping 0xFFFFFFFF -> 0.
REQ-018 Hold-buffer contents SHALL never be lost or reordered relative to later ALU results.

Reset
REQ-019 On rstn low, the block SHALL immediately clear wr_en, wr_addr, wr_data, load_err, wb_count and hold_v to 0; alu_ready SHALL read 1.
REQ-020 Reset asserted mid-operation SHALL discard the hold entry and any in-flight write; no write SHALL occur in the first cycle after release.

Verification
REQ-021 The bench SHALL cover: ALU only, rd=5, result 0x12345678 -> next cycle wr_en=1, wr_addr=5, wr_data=0x12345678, wb_count=1.
REQ-022 The bench SHALL cover: mem LB, addr_lo=3, rdata=0x80FFFFFF, rd=7 -> wr_data=0xFFFFFF80; same with LBU -> 0x00000080.
REQ-023 The bench SHALL cover: mem (rd=1) and ALU (rd=2, 0xAA) valid in the same cycle -> cycle+1 writes x1; alu_ready=0 in cycle+1; cycle+2 writes x2=0xAA; alu_ready=1 in cycle+2.
REQ-024 The bench SHALL cover: LW with addr_lo=2 -> wr_en=0, load_err pulses 1 cycle, wb_count unchanged.
REQ-025 The bench SHALL cover: ALU rd=0 -> wr_en=0, wb_count unchanged.
REQ-026 The bench SHALL cover: hold_v=1, rstn pulsed low -> all outputs 0, alu_ready=1, no write after release.

Source files
------------

// File: rtl/wb_stage.sv
// wb_stage -- register-file write-back stage.
//
// Merges two result sources into a single register-file write port:
//   - ALU results, flow-controlled with alu_valid/alu_ready.
//   - Load data, which is never stalled (no ready).
// When both sources arrive in the same cycle, the load wins and the ALU
// result is parked in a one-entry hold buffer. That entry drains on the
// next cycle without a load. The ALU is held off (alu_ready low) while the
// buffer is full, so ALU results keep their original order.
//
// Ports:
//   clk, rstn           clock, asynchronous active-low reset
//   alu_valid/ready     ALU handshake; alu_ready = !hold_v
//   alu_rd, alu_result  ALU destination register and value
//   mem_valid           load data offered (always accepted)
//   mem_rd              load destination register
//   mem_funct3          load type: LB/LH/LW/LBU/LHU
//   mem_addr_lo         load byte address [1:0]
//   mem_rdata           raw data-memory word
//   wr_en/addr/data     registered register-file write port
//   load_err            one-cycle pulse for a misaligned or illegal load
//   wb_count            number of committed register writes (wraps)

module wb_stage (
    input  logic        clk,
    input  logic        rstn,
    input  logic        alu_valid,
    output logic        alu_ready,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_result,
    input  logic        mem_valid,
    input  logic [4:0]  mem_rd,
    input  logic [2:0]  mem_funct3,
    input  logic [1:0]  mem_addr_lo,
    input  logic [31:0] mem_rdata,
    output logic        wr_en,
    output logic [4:0]  wr_addr,
    output logic [31:0] wr_data,
    output logic        load_err,
    output logic [31:0] wb_count
);

    logic        hold_v;
    logic [4:0]  hold_rd;
    logic [31:0] hold_data;

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;
    logic        ld_err;

    logic        sel_v;
    logic [4:0]  sel_rd;
    logic [31:0] sel_data;
    logic        sel_err;
    logic        cap_hold;
    logic        clr_hold;

    assign alu_ready = !hold_v;

    // Load alignment and extension
    always_comb begin
        ld_byte = 8'h00;
        ld_half = mem_addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        ld_data = 32'h0;
        ld_err  = 1'b0;
        case (mem_addr_lo)
            2'd0:    ld_byte = mem_rdata[7:0];
            2'd1:    ld_byte = mem_rdata[15:8];
            2'd2:    ld_byte = mem_rdata[23:16];
            default: ld_byte = mem_rdata[31:24];
        endcase
        case (mem_funct3)
            3'b000: ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b100: ld_data = {24'h0, ld_byte};
            3'b001: begin
                ld_data = {{16{ld_half[15]}}, ld_half};
                ld_err  = mem_addr_lo[0];
            end
            3'b101: begin
                ld_data = {16'h0, ld_half};
                ld_err  = mem_addr_lo[0];
            end
            3'b010: begin
                ld_data = mem_rdata;
                ld_err  = (mem_addr_lo != 2'd0);
            end
            default: ld_err = 1'b1;
        endcase
    end

    // Source selection: load > hold buffer > ALU
    always_comb begin
        sel_v    = 1'b0;
        sel_rd   = 5'd0;
        sel_data = 32'h0;
        sel_err  = 1'b0;
        cap_hold = 1'b0;
        clr_hold = 1'b0;
        if (mem_valid) begin
            sel_v    = 1'b1;
            sel_rd   = mem_rd;
            sel_data = ld_data;
            sel_err  = ld_err;
            cap_hold = alu_valid && !hold_v;
        end else if (hold_v) begin
            sel_v    = 1'b1;
            sel_rd   = hold_rd;
            sel_data = hold_data;
            clr_hold = 1'b1;
        end else if (alu_valid) begin
            sel_v    = 1'b1;
            sel_rd   = alu_rd;
            sel_data = alu_result;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_en     <= 1'b0;
            wr_addr   <= 5'd0;
            wr_data   <= 32'h0;
            load_err  <= 1'b0;
            wb_count  <= 32'h0;
            hold_v    <= 1'b0;
            hold_rd   <= 5'd0;
            hold_data <= 32'h0;
        end else begin
            wr_en    <= 1'b0;
            load_err <= sel_v && sel_err;
            // x0 writes and faulted loads are consumed silently; the
            // write port keeps its last address/data in that case.
            if (sel_v && !sel_err && (sel_rd != 5'd0)) begin
                wr_en    <= 1'b1;
                wr_addr  <= sel_rd;
                wr_data  <= sel_data;
                wb_count <= wb_count + 32'd1;
            end
            if (cap_hold) begin
                hold_v    <= 1'b1;
                hold_rd   <= alu_rd;
                hold_data <= alu_result;
            end else if (clr_hold) begin
                hold_v <= 1'b0;
            end
        end
    end

endmodule
